// File: rtl/p405s_gprPkg.sv
// Shared GPR write-port tracking types.
// Slot record, slot index enum and address width.
package p405s_gprPkg;

    localparam int ADDR_W = 10;
    localparam int NSLOT  = 6;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } slot_t;

    typedef enum logic [2:0] {
        EXE_RP,
        EXE_MORM,
        EXE_LP,
        WB_RP,
        WB_LP,
        LWB_LP
    } slot_e;

    function automatic logic slot_hit(
        input slot_t s,
        input addr_t a
    );
        return s.valid && (s.addr == a);
    endfunction

endpackage

// File: rtl/p405s_wPortCmp.sv
// One read address against the five bypassable writer slots.
// Instantiated once per decode read port.
module p405s_wPortCmp
    import p405s_gprPkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  slot_t             i_exeRp,
    input  slot_t             i_exeMorM,
    input  slot_t             i_wbRp,
    input  slot_t             i_wbLp,
    input  slot_t             i_lwbLp,
    output logic              o_eqExeRp,
    output logic              o_eqExeMorM,
    output logic              o_eqWbRp,
    output logic              o_eqWbLp,
    output logic              o_eqLwbLp
);

    assign o_eqExeRp   = slot_hit(i_exeRp, i_addr);
    assign o_eqExeMorM = slot_hit(i_exeMorM, i_addr);
    assign o_eqWbRp    = slot_hit(i_wbRp, i_addr);
    assign o_eqWbLp    = slot_hit(i_wbLp, i_addr);
    assign o_eqLwbLp   = slot_hit(i_lwbLp, i_addr);

endmodule

// File: rtl/p405s_wporttrack.sv
// GPR write-port destination tracker: in-flight writer slots,
// write-port drive and decode-vs-writer address compares.
module p405s_wporttrack
    import p405s_gprPkg::*;
(
    input  logic              CB,
    input  logic              resetN,
    input  logic              dcdAdvance,
    input  logic              dcdRpWrEn,
    input  logic              dcdMorM,
    input  logic              dcdLpWrEn,
    input  logic [ADDR_W-1:0] dcdRpWrAddr,
    input  logic [ADDR_W-1:0] dcdLpWrAddr,
    input  logic              exeAdvance,
    input  logic              exeFlush,
    input  logic              morMDone,
    input  logic              lpDataValid,
    input  logic [ADDR_W-1:0] preDcdRA,
    input  logic [ADDR_W-1:0] preDcdRSRT,
    output logic              dcdRAEqexeRpAddr,
    output logic              dcdRAEqexeMorMRpAddr,
    output logic              dcdRAEqwbRpAddr,
    output logic              dcdRAEqwbLpAddr,
    output logic              dcdRAEqlwbLpAddr,
    output logic              dcdRSEqexeRpAddr,
    output logic              dcdRSEqexeMorMRpAddr,
    output logic              dcdRSEqwbRpAddr,
    output logic              dcdRSEqwbLpAddr,
    output logic              dcdRSEqlwbLpAddr,
    output logic              gprRpWrEn,
    output logic [ADDR_W-1:0] gprRpWrAddr,
    output logic              gprLpWrEn,
    output logic [ADDR_W-1:0] gprLpWrAddr,
    output logic              rpWbConflict,
    output logic              lpHold
);

    slot_t r_slot [NSLOT];
    slot_t w_nxt  [NSLOT];

    logic w_issueRp;
    logic w_issueMorM;
    logic w_issueLp;
    logic w_morRet;
    logic w_rpGo;
    logic w_lpGo;
    logic w_wbV;
    logic w_lwbV;
    logic w_lwbRet;
    logic w_wbRet;
    logic w_wbStay;
    logic w_lwbFree;
    logic w_wbToLwb;

    assign w_issueRp   = dcdAdvance & dcdRpWrEn & ~dcdMorM;
    assign w_issueMorM = dcdAdvance & dcdRpWrEn & dcdMorM;
    assign w_issueLp   = dcdAdvance & dcdLpWrEn;

    assign w_morRet = morMDone & r_slot[EXE_MORM].valid;
    assign rpWbConflict = morMDone & r_slot[EXE_RP].valid;
    // MorM owns wbRp on a conflict; exeRp waits in place.
    assign w_rpGo = exeAdvance & ~rpWbConflict;

    assign w_wbV  = r_slot[WB_LP].valid;
    assign w_lwbV = r_slot[LWB_LP].valid;

    // Load data always belongs to the oldest outstanding load.
    assign w_lwbRet  = lpDataValid & w_lwbV;
    assign w_wbRet   = lpDataValid & ~w_lwbV & w_wbV;
    assign w_wbStay  = w_wbV & ~w_wbRet;
    assign w_lwbFree = ~w_lwbV | w_lwbRet;
    assign w_wbToLwb = w_wbStay & w_lwbFree;

    assign lpHold = w_wbStay & ~w_lwbFree;
    assign w_lpGo = exeAdvance & ~lpHold;

    always_comb begin
        w_nxt = r_slot;

        if (exeFlush) begin
            w_nxt[EXE_RP].valid = 1'b0;
        end else if (w_issueRp) begin
            w_nxt[EXE_RP] = '{1'b1, dcdRpWrAddr};
        end else if (w_rpGo) begin
            w_nxt[EXE_RP].valid = 1'b0;
        end

        if (w_issueMorM) begin
            w_nxt[EXE_MORM] = '{1'b1, dcdRpWrAddr};
        end else if (morMDone) begin
            w_nxt[EXE_MORM].valid = 1'b0;
        end

        if (exeFlush) begin
            w_nxt[EXE_LP].valid = 1'b0;
        end else if (w_issueLp) begin
            w_nxt[EXE_LP] = '{1'b1, dcdLpWrAddr};
        end else if (w_lpGo) begin
            w_nxt[EXE_LP].valid = 1'b0;
        end

        // A flushed exe entry must not reach writeback.
        if (w_morRet) begin
            w_nxt[WB_RP] = r_slot[EXE_MORM];
        end else if (w_rpGo) begin
            w_nxt[WB_RP] = '{r_slot[EXE_RP].valid & ~exeFlush,
                             r_slot[EXE_RP].addr};
        end else begin
            w_nxt[WB_RP].valid = 1'b0;
        end

        if (w_wbToLwb) begin
            w_nxt[LWB_LP] = r_slot[WB_LP];
        end else if (w_lwbRet) begin
            w_nxt[LWB_LP].valid = 1'b0;
        end

        if (w_lpGo) begin
            w_nxt[WB_LP] = '{r_slot[EXE_LP].valid & ~exeFlush,
                             r_slot[EXE_LP].addr};
        end else if (w_wbToLwb | w_wbRet) begin
            w_nxt[WB_LP].valid = 1'b0;
        end
    end

    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            r_slot <= '{default: '0};
        end else begin
            r_slot <= w_nxt;
        end
    end

    assign gprRpWrEn   = r_slot[WB_RP].valid;
    assign gprRpWrAddr = gprRpWrEn ? r_slot[WB_RP].addr : '0;

    assign gprLpWrEn   = lpDataValid & (w_lwbV | w_wbV);
    assign gprLpWrAddr = !gprLpWrEn ? '0 :
                         w_lwbV     ? r_slot[LWB_LP].addr :
                                      r_slot[WB_LP].addr;

    p405s_wPortCmp u_cmpRA (
        .i_addr      (preDcdRA),
        .i_exeRp     (r_slot[EXE_RP]),
        .i_exeMorM   (r_slot[EXE_MORM]),
        .i_wbRp      (r_slot[WB_RP]),
        .i_wbLp      (r_slot[WB_LP]),
        .i_lwbLp     (r_slot[LWB_LP]),
        .o_eqExeRp   (dcdRAEqexeRpAddr),
        .o_eqExeMorM (dcdRAEqexeMorMRpAddr),
        .o_eqWbRp    (dcdRAEqwbRpAddr),
        .o_eqWbLp    (dcdRAEqwbLpAddr),
        .o_eqLwbLp   (dcdRAEqlwbLpAddr)
    );

    p405s_wPortCmp u_cmpRS (
        .i_addr      (preDcdRSRT),
        .i_exeRp     (r_slot[EXE_RP]),
        .i_exeMorM   (r_slot[EXE_MORM]),
        .i_wbRp      (r_slot[WB_RP]),
        .i_wbLp      (r_slot[WB_LP]),
        .i_lwbLp     (r_slot[LWB_LP]),
        .o_eqExeRp   (dcdRSEqexeRpAddr),
        .o_eqExeMorM (dcdRSEqexeMorMRpAddr),
        .o_eqWbRp    (dcdRSEqwbRpAddr),
        .o_eqWbLp    (dcdRSEqwbLpAddr),
        .o_eqLwbLp   (dcdRSEqlwbLpAddr)
    );

endmodule

// File: tb/tb_p405s_wporttrack.sv
// Bench for p405s_wporttrack: directed scenarios plus random
// traffic against a load-queue reference model.
module tb_p405s_wporttrack;

    logic       CB = 1'b0;
    logic       resetN = 1'b0;
    logic       dcdAdvance, dcdRpWrEn, dcdMorM, dcdLpWrEn;
    logic [9:0] dcdRpWrAddr, dcdLpWrAddr;
    logic       exeAdvance, exeFlush, morMDone, lpDataValid;
    logic [9:0] preDcdRA, preDcdRSRT;
    logic       raExeRp, raMorM, raWbRp, raWbLp, raLwbLp;
    logic       rsExeRp, rsMorM, rsWbRp, rsWbLp, rsLwbLp;
    logic       gprRpWrEn, gprLpWrEn, rpWbConflict, lpHold;
    logic [9:0] gprRpWrAddr, gprLpWrAddr;

    always #5 CB = ~CB;

    p405s_wporttrack dut (
        .CB                   (CB),
        .resetN               (resetN),
        .dcdAdvance           (dcdAdvance),
        .dcdRpWrEn            (dcdRpWrEn),
        .dcdMorM              (dcdMorM),
        .dcdLpWrEn            (dcdLpWrEn),
        .dcdRpWrAddr          (dcdRpWrAddr),
        .dcdLpWrAddr          (dcdLpWrAddr),
        .exeAdvance           (exeAdvance),
        .exeFlush             (exeFlush),
        .morMDone             (morMDone),
        .lpDataValid          (lpDataValid),
        .preDcdRA             (preDcdRA),
        .preDcdRSRT           (preDcdRSRT),
        .dcdRAEqexeRpAddr     (raExeRp),
        .dcdRAEqexeMorMRpAddr (raMorM),
        .dcdRAEqwbRpAddr      (raWbRp),
        .dcdRAEqwbLpAddr      (raWbLp),
        .dcdRAEqlwbLpAddr     (raLwbLp),
        .dcdRSEqexeRpAddr     (rsExeRp),
        .dcdRSEqexeMorMRpAddr (rsMorM),
        .dcdRSEqwbRpAddr      (rsWbRp),
        .dcdRSEqwbLpAddr      (rsWbLp),
        .dcdRSEqlwbLpAddr     (rsLwbLp),
        .gprRpWrEn            (gprRpWrEn),
        .gprRpWrAddr          (gprRpWrAddr),
        .gprLpWrEn            (gprLpWrEn),
        .gprLpWrAddr          (gprLpWrAddr),
        .rpWbConflict         (rpWbConflict),
        .lpHold               (lpHold)
    );

    int nChk = 0;
    int nPass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: exe and wbRp entries, plus a queue of loads past exe
    // (oldest first); a single entry is in wb only in its first cycle.
    typedef struct {
        logic [9:0] a;
        bit         fresh;
    } ld_t;

    bit         mRpV, mMorV, mLpV, mWbV;
    logic [9:0] mRpA, mMorA, mLpA, mWbA;
    ld_t        lq[$];

    task automatic model_reset();
        mRpV = 0; mMorV = 0; mLpV = 0; mWbV = 0;
        mRpA = 0; mMorA = 0; mLpA = 0; mWbA = 0;
        lq.delete();
    endtask

    task automatic lp_view(output bit wv, output logic [9:0] wa,
                           output bit lv, output logic [9:0] la);
        wv = 0; lv = 0; wa = 0; la = 0;
        if (lq.size() == 2) begin
            lv = 1; la = lq[0].a; wv = 1; wa = lq[1].a;
        end else if (lq.size() == 1) begin
            if (lq[0].fresh) begin wv = 1; wa = lq[0].a; end
            else begin lv = 1; la = lq[0].a; end
        end
    endtask

    task automatic check_outs();
        bit wv, lv, ldOut;
        logic [9:0] wa, la;
        lp_view(wv, wa, lv, la);
        ldOut = lpDataValid && lq.size() > 0;
        chk("raExeRp", raExeRp, mRpV && preDcdRA == mRpA);
        chk("raMorM", raMorM, mMorV && preDcdRA == mMorA);
        chk("raWbRp", raWbRp, mWbV && preDcdRA == mWbA);
        chk("raWbLp", raWbLp, wv && preDcdRA == wa);
        chk("raLwbLp", raLwbLp, lv && preDcdRA == la);
        chk("rsExeRp", rsExeRp, mRpV && preDcdRSRT == mRpA);
        chk("rsMorM", rsMorM, mMorV && preDcdRSRT == mMorA);
        chk("rsWbRp", rsWbRp, mWbV && preDcdRSRT == mWbA);
        chk("rsWbLp", rsWbLp, wv && preDcdRSRT == wa);
        chk("rsLwbLp", rsLwbLp, lv && preDcdRSRT == la);
        chk("rpWrEn", gprRpWrEn, mWbV);
        chk("rpWrAddr", gprRpWrAddr, mWbV ? mWbA : 10'd0);
        chk("lpWrEn", gprLpWrEn, ldOut);
        chk("lpWrAddr", gprLpWrAddr, ldOut ? lq[0].a : 10'd0);
        chk("conflict", rpWbConflict, morMDone && mRpV);
        chk("lpHold", lpHold, lq.size() == 2 && !lpDataValid);
    endtask

    task automatic model_step();
        bit issRp, issMm, issLp, confl, hold, lpMove;
        issRp = dcdAdvance && dcdRpWrEn && !dcdMorM;
        issMm = dcdAdvance && dcdRpWrEn && dcdMorM;
        issLp = dcdAdvance && dcdLpWrEn;
        assert (!(issMm && mMorV && !morMDone))
            else $error("illegal second MorM issue");
        confl  = morMDone && mRpV;
        hold   = lq.size() == 2 && !lpDataValid;
        lpMove = exeAdvance && !hold;
        if (lpDataValid && lq.size() > 0) void'(lq.pop_front());
        foreach (lq[i]) lq[i].fresh = 0;
        if (lpMove && mLpV && !exeFlush) lq.push_back('{mLpA, 1'b1});
        if (morMDone && mMorV) begin
            mWbV = 1; mWbA = mMorA;
        end else if (exeAdvance && !confl && mRpV && !exeFlush) begin
            mWbV = 1; mWbA = mRpA;
        end else begin
            mWbV = 0;
        end
        if (issMm) begin mMorV = 1; mMorA = dcdRpWrAddr; end
        else if (morMDone) mMorV = 0;
        if (exeFlush) mRpV = 0;
        else if (issRp) begin mRpV = 1; mRpA = dcdRpWrAddr; end
        else if (exeAdvance && !confl) mRpV = 0;
        if (exeFlush) mLpV = 0;
        else if (issLp) begin mLpV = 1; mLpA = dcdLpWrAddr; end
        else if (lpMove) mLpV = 0;
    endtask

    task automatic apply(input bit adv, rp, mm, lp,
                         input logic [9:0] ra, la,
                         input bit ea, fl, md, dv);
        dcdAdvance = adv; dcdRpWrEn = rp; dcdMorM = mm;
        dcdLpWrEn = lp; dcdRpWrAddr = ra; dcdLpWrAddr = la;
        exeAdvance = ea; exeFlush = fl; morMDone = md;
        lpDataValid = dv;
        #1;
        check_outs();
    endtask

    task automatic tick();
        @(posedge CB);
        model_step();
        @(negedge CB);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit adv, rp, mm, lp, ea, fl, md, dv, hold, confl;
        preDcdRA = 0; preDcdRSRT = 0;
        model_reset();
        @(negedge CB);
        idle();
        chk("rstLpHold", lpHold, 0);
        resetN = 1'b1;

        // fill all six slots
        preDcdRA = 10'h011; preDcdRSRT = 10'h012;
        apply(1, 0, 0, 1, 0, 10'h011, 0, 0, 0, 0); tick();
        apply(1, 0, 0, 1, 0, 10'h012, 1, 0, 0, 0); tick();
        apply(1, 1, 0, 1, 10'h005, 10'h013, 1, 0, 0, 0); tick();
        apply(1, 1, 1, 0, 10'h00A, 0, 0, 0, 0, 0);
        chk("dirHold", lpHold, 1);
        chk("dirLwb", raLwbLp, 1);
        chk("dirWbLp", rsWbLp, 1);
        tick();
        apply(1, 1, 1, 0, 10'h00B, 0, 0, 0, 1, 0);
        chk("dirConflict", rpWbConflict, 1);
        tick();
        preDcdRA = 10'h00A; preDcdRSRT = 10'h005;
        idle();
        chk("dirWbRpMorM", raWbRp, 1);
        chk("dirExeRpKept", rsExeRp, 1);
        chk("dirRpAddr", gprRpWrAddr, 10'h00A);

        // asynchronous reset with every slot valid
        #2 resetN = 1'b0;
        model_reset();
        #1 check_outs();
        chk("rstRpWrEn", gprRpWrEn, 0);
        chk("rstRaWbRp", raWbRp, 0);
        @(negedge CB);
        resetN = 1'b1;
        idle(); tick();
        idle(); tick();

        // Rp forwarding
        preDcdRA = 10'h005;
        apply(1, 1, 0, 0, 10'h005, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("fwdExeRp", raExeRp, 1);
        tick();
        idle();
        chk("fwdWbRp", raWbRp, 1);
        chk("fwdWrEn", gprRpWrEn, 1);
        chk("fwdWrAddr", gprRpWrAddr, 10'h005);
        tick();
        idle();
        chk("fwdWrEnOff", gprRpWrEn, 0);
        tick();

        // flush beats same-cycle refill, MorM survives
        apply(1, 1, 1, 1, 10'h00A, 10'h007, 0, 0, 0, 0); tick();
        apply(1, 1, 0, 0, 10'h003, 0, 0, 1, 0, 0); tick();
        preDcdRA = 10'h003; preDcdRSRT = 10'h00A;
        idle();
        chk("flushExeRp", raExeRp, 0);
        chk("flushMorM", rsMorM, 1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); tick();

        // random traffic under the control-side rules
        for (int c = 0; c < 3000; c++) begin
            dv = $urandom_range(0, 2) == 0;
            hold = lq.size() == 2 && !dv;
            md = mMorV && $urandom_range(0, 3) == 0;
            confl = md && mRpV;
            ea = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (confl) ea = $urandom_range(0, 3) == 0;
            fl = $urandom_range(0, 15) == 0;
            adv = ((!mRpV || (ea && !confl)) && (!mLpV || ea)) || fl;
            adv = adv && $urandom_range(0, 2) != 0;
            rp = $urandom_range(0, 1);
            mm = $urandom_range(0, 3) == 0;
            lp = $urandom_range(0, 1);
            if (rp && mm && mMorV && !md) mm = 0;
            preDcdRA = $urandom_range(0, 7);
            preDcdRSRT = ($urandom_range(0, 15) == 0) ?
                         10'($urandom_range(0, 1023)) :
                         10'($urandom_range(0, 7));
            apply(adv, rp, mm, lp, 10'($urandom_range(0, 7)),
                  10'($urandom_range(0, 7)), ea, fl, md, dv);
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule

// File: doc/p405s_wporttrack.md
# p405s_wPortTrack

GPR write-port destination tracker for the p405s integer pipeline. Holds the target register address and valid bit of every in-flight writer: exe result port, exe multi-cycle (MorM), writeback result port, writeback load port and late-writeback load port. Drives the GPR write-port enables and addresses. Produces the ten decode-versus-writer address compares (`dcdRAEq*`, `dcdRSEq*`) that the A-port and B-port read muxes consume for bypass select and hazard detection.

## Interface
- `ADDR_W`, 10, GPR address width; matches `preDcdRA` / `preDcdRSRT`
- `CB` in 1: core clock; all state changes on the rising edge
- `resetN` in 1: reset, asynchronous, active-low
- `dcdAdvance` in 1: the decode instruction enters exe this cycle
- `dcdRpWrEn` in 1: decode instruction writes the GPR via the result port
- `dcdMorM` in 1: that Rp write is multi-cycle (mul/div) and goes to the MorM slot
- `dcdLpWrEn` in 1: decode instruction is a load with a GPR target
- `dcdRpWrAddr`, `dcdLpWrAddr` in ADDR_W: target addresses
- `exeAdvance` in 1: exe contents move to wb
- `exeFlush` in 1: kill exe-stage Rp and Lp entries
- `morMDone` in 1: the multi-cycle result is available this cycle
- `lpDataValid` in 1: load data returns for the oldest outstanding load
- `preDcdRA`, `preDcdRSRT` in ADDR_W: decode read addresses
- `dcdRAEqexeRpAddr`, `dcdRAEqexeMorMRpAddr`, `dcdRAEqwbRpAddr`, `dcdRAEqwbLpAddr`, `dcdRAEqlwbLpAddr` out 1 each: RA compares
- `dcdRSEq*` out 1 each: the same five compares for RS/RT
- `gprRpWrEn` out 1, `gprRpWrAddr` out ADDR_W: GPR result write port
- `gprLpWrEn` out 1, `gprLpWrAddr` out ADDR_W: GPR load write port
- `rpWbConflict` out 1: `morMDone` and a valid `exeRp` are contending for wbRp
- `lpHold` out 1: wbLp cannot retire to lwbLp

## Operation
- **Slots.** exeRp, exeMorM, exeLp, wbRp, wbLp and lwbLp. Each slot is a valid bit plus an ADDR_W address.
- **Issue.**
  - On `dcdAdvance` with `dcdRpWrEn` and `!dcdMorM`, load exeRp.
  - On `dcdAdvance` with `dcdRpWrEn` and `dcdMorM`, load exeMorM.
  - On `dcdAdvance` with `dcdLpWrEn`, load exeLp.
  - exeMorM already valid plus a new MorM issue is illegal; it is flagged by a bench assertion only.
- **exe to wb.**
  - On `exeAdvance`: exeRp moves to wbRp and exeLp moves to wbLp.
  - If `dcdAdvance` does not refill a slot, its valid bit clears.
- **MorM retire.** On `morMDone`, exeMorM moves to wbRp and exeMorM clears.
  - `rpWbConflict` is asserted combinationally when `morMDone & exeRpV`.
  - While it is asserted, control must hold `exeAdvance` low.
  - If `exeAdvance` is asserted anyway, MorM wins and the exeRp entry stays in place.
- **wbRp.** Valid for exactly one cycle per entry. `gprRpWrEn = wbRpV`. The slot clears unless it is refilled.
- **Load ports.**
  - The oldest outstanding load is lwbLp if valid, otherwise wbLp. `lpDataValid` retires the oldest one.
  - `gprLpWrEn = lpDataValid & (lwbLpV | wbLpV)`. Its address is lwbLp if lwbLpV, otherwise wbLp.
  - A wbLp entry not retired in its wb cycle moves to lwbLp when lwbLp is empty or is retiring this cycle.
  - Otherwise wbLp stays and `lpHold = 1`; control must hold `exeAdvance` while `lpHold` is high.
  - `lpDataValid` with no load outstanding is ignored.
- **Flush.** `exeFlush` clears exeRp and exeLp valid. It has priority over a same-cycle `dcdAdvance` refill. exeMorM and the wb/lwb slots are unaffected.
- **Compares.** `dcdRAEqX = XV & (preDcdRA == XAddr)`. RS compares are the same with `preDcdRSRT`. All are combinational from registered state.

## Timing
- **Reset.** All valid bits are 0 and all addresses are 0. All outputs are 0, including every compare, both write enables, `rpWbConflict` and `lpHold`. Reset mid-operation discards in-flight entries immediately (asynchronous).
- **Issue to visibility.** An entry issued at edge N is visible in the compares in cycle N+1.
- **Writeback.** A wb-stage entry drives `gprRpWrEn` in the cycle after `exeAdvance`.
- **Load latency.** Load data can arrive in the wb cycle (wbLp retire) or any later cycle (lwbLp retire). There is no upper bound.
- **Same-edge move.** A slot vacating and refilling on the same edge shows the new address the next cycle with no bubble.
- **Combinational outputs.** The compares, write enables, `rpWbConflict` and `lpHold` have no internal register.

## Structure
- **Shared package `p405s_gprPkg`.** Holds `ADDR_W`, the slot record typedef {valid, addr}, and the slot index enum: EXE_RP, EXE_MORM, EXE_LP, WB_RP, WB_LP, LWB_LP.
- **Sub-module `p405s_wPortCmp`.** Instantiated twice, once for RA and once for RS. It takes one read address and five slot records and produces five Eq outputs.
- **Top level.** Slot registers and move/retire logic.

## Test plan
- **Reset.** Assert `resetN=0` mid-stream with all six slots valid. All outputs are 0 at once; after release, the compares stay 0 until a new issue.
- **Rp forwarding.** Issue Rp to addr 0x005. Next cycle `dcdRAEqexeRpAddr=1` when `preDcdRA=0x005`. After `exeAdvance`, `dcdRAEqwbRpAddr=1`, `gprRpWrEn=1` and `gprRpWrAddr=0x005` for one cycle, then all 0.
- **MorM conflict.** exeMorM=0x00A with exeRp=0x003 valid. On `morMDone`, `rpWbConflict=1`. Next cycle wbRp=0x00A and exeRp still holds 0x003.
- **Late load.** A load to 0x011 reaches wb with `lpDataValid=0`, moves to lwbLp, and `dcdRSEqlwbLpAddr` asserts. Later `lpDataValid` gives `gprLpWrEn=1` with addr 0x011.
- **lpHold.** lwbLp=0x011 pending and wbLp=0x012 without data, so `lpHold=1`. `lpDataValid` retires 0x011 and the same edge moves 0x012 into lwbLp.
- **Flush.** `exeFlush` with a same-cycle `dcdAdvance` and Rp issue: exeRp and exeLp are invalid next cycle, and exeMorM is retained.
